// File: rtl/alu_dispatch_ctrl.sv
// alu_dispatch_ctrl: FIFO-buffered ALU sequencer with multi-cycle MUL hold and GPR write-port arbitration.
// Define ALU_DISPATCH_PERF_EN to build the perf_issued/perf_stall counters; otherwise they read 0.
module alu_dispatch_ctrl #(
  parameter int DEPTH       = 4,
  parameter int MUL_LAT     = 3,
  parameter int STALL_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_inst,
  output logic        alu_en,
  output logic [47:0] alu_inst,
  input  logic        alu_done,
  input  logic [15:0] alu_gpr_we,
  output logic [15:0] gpr_we,
  input  logic        mem_wb_req,
  output logic        mem_wb_gnt,
  output logic        busy,
  output logic        drop,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_stall
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = MUL_LAT > 1 ? $clog2(MUL_LAT) : 1;
  localparam int SW = $clog2(STALL_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, EXEC, STALL} state_t;
  state_t state, state_nxt;
  logic [47:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [LW-1:0] cnt, lat_m1;
  logic [SW-1:0] stall_cnt;
  logic [47:0] head;
  logic push, pop, head_alu, fin, commit;
  assign head      = mem[rd_ptr];
  assign head_alu  = head[2:0] == 3'b100;
  assign lat_m1    = head[7:4] == 4'b1110 ? LW'(MUL_LAT - 1) : '0;
  assign in_ready  = count < CW'(DEPTH);
  assign push      = in_valid && in_ready;
  assign count_nxt = count + CW'(push) - CW'(pop);
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_inst;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count_nxt;
    end
  end
  // cnt paces the MUL hold; stall_cnt counts denied STALL cycles toward the forced commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      stall_cnt <= '0;
    end else begin
      cnt       <= (state == IDLE || pop) ? '0 :
                   (state == EXEC && head_alu && cnt < lat_m1) ? cnt + 1'b1 : cnt;
      stall_cnt <= commit ? '0 : state == STALL ? stall_cnt + 1'b1 : stall_cnt;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    if (state == IDLE)          state_nxt = count != '0 ? EXEC : IDLE;
    else if (pop)               state_nxt = count_nxt != '0 ? EXEC : IDLE;
    else if (fin && mem_wb_req) state_nxt = STALL;
  end
  always_comb begin
    alu_en     = state == STALL || (state == EXEC && head_alu);
    drop       = state == EXEC && !head_alu;
    fin        = state == EXEC && head_alu && cnt == lat_m1 && alu_done;
    commit     = (fin && !mem_wb_req) ||
                 (state == STALL && (!mem_wb_req || stall_cnt == SW'(STALL_LIMIT)));
    pop        = commit || drop;
    gpr_we     = commit ? alu_gpr_we : '0;
    mem_wb_gnt = mem_wb_req && !commit && !rst;
    alu_inst   = alu_en ? head : '0;
    busy       = count != '0 || state != IDLE;
  end
`ifdef ALU_DISPATCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (commit)                   perf_issued <= perf_issued + 32'd1;
      if (state == STALL && !commit) perf_stall <= perf_stall + 32'd1;
    end
  end
`else
  assign perf_issued = '0;
  assign perf_stall  = '0;
`endif
endmodule
